// File: rtl/boid_xcel_pkg.sv
// ---------------------------------------------------------------------------
// boid_xcel_pkg
// Shared definitions for the boid accelerator sequencer.
//   seq_state_e     : sequencer states (IDLE, SA_INIT, SA_LD, SA_CALC, AC_WB)
//   WB_*            : bit positions of the write-back field enables
//   WB_MASK_DEFAULT : fields written back after a boid is fully accumulated
//   ceil_div()      : neighbour group count for a given boid/lane count
// ---------------------------------------------------------------------------
package boid_xcel_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SA_INIT,
      SA_LD,
      SA_CALC,
      AC_WB
   } seq_state_e;

   localparam int WB_WIDTH   = 7;
   localparam int WB_POS_X   = 0;
   localparam int WB_POS_Y   = 1;
   localparam int WB_VEL_X   = 2;
   localparam int WB_VEL_Y   = 3;
   localparam int WB_HEADING = 4;
   localparam int WB_NCOUNT  = 5;
   localparam int WB_FLAGS   = 6;

   // Position, velocity and heading are rewritten every frame; the neighbour
   // count and flag fields are left to the host by default.
   localparam logic [WB_WIDTH-1:0] WB_MASK_DEFAULT =
      WB_WIDTH'((1 << WB_POS_X) | (1 << WB_POS_Y) | (1 << WB_VEL_X) |
                (1 << WB_VEL_Y) | (1 << WB_HEADING));

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/boid_fall_edge_det.sv
// ---------------------------------------------------------------------------
// boid_fall_edge_det
// Registered 1-bit falling-edge detector.
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   i_level  : level being watched
//   o_fall   : one-cycle pulse, one cycle after i_level is first sampled low
//              following a high sample
// ---------------------------------------------------------------------------
module boid_fall_edge_det (
   input  logic clk,
   input  logic reset_n,
   input  logic i_level,
   output logic o_fall
);

   logic r_prev;
   logic r_fall;

   // The pulse itself is registered so the sequencer never sees a
   // combinational path from the trigger inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_prev <= i_level;
         r_fall <= r_prev & ~i_level;
      end
   end

   assign o_fall = r_fall;

endmodule

// File: rtl/boid_xcel_seq.sv
// ---------------------------------------------------------------------------
// boid_xcel_seq
// Sequencer for the boid accelerator datapath. Walks each boid as "self"
// against all boids as neighbours, NUM_LANES neighbours per calc cycle.
//   clk, reset_n          : clock, asynchronous active-low reset
//   en, is_refilling      : ORed frame trigger; a falling edge starts a frame
//   mem_valid             : memory data valid for the pending read request
//   step_mode, step       : when step_mode=1, AC_WB waits for a step pulse
//   which_boid, nbr_base  : self index, index of lane 0's neighbour
//   lane_mask             : per-lane neighbour valid
//   r_en_tot, r_en_itr    : self-state / neighbour-group read requests
//   calc_en, wb_en        : accumulate strobe, write-back field enables
//   busy, frame_done      : not idle, end-of-frame pulse
// ---------------------------------------------------------------------------
module boid_xcel_seq
   import boid_xcel_pkg::*;
#(
   parameter int                  NUM_BOIDS = 8,
   parameter int                  NUM_LANES = 2,
   parameter logic [WB_WIDTH-1:0] WB_MASK   = WB_MASK_DEFAULT,
   localparam int IW = ($clog2(NUM_BOIDS) > 1) ? $clog2(NUM_BOIDS) : 1
)(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 en,
   input  logic                 is_refilling,
   input  logic                 mem_valid,
   input  logic                 step_mode,
   input  logic                 step,
   output logic [IW-1:0]        which_boid,
   output logic [IW-1:0]        nbr_base,
   output logic [NUM_LANES-1:0] lane_mask,
   output logic                 r_en_tot,
   output logic                 r_en_itr,
   output logic                 calc_en,
   output logic [WB_WIDTH-1:0]  wb_en,
   output logic                 busy,
   output logic                 frame_done
);

   // Counter width leaves headroom so nbr_ctr + lane never wraps.
   localparam int            CW      = $clog2(NUM_BOIDS + NUM_LANES) + 1;
   localparam logic [CW-1:0] C_BOIDS = CW'(NUM_BOIDS);
   localparam logic [CW-1:0] C_LANES = CW'(NUM_LANES);
   localparam logic [CW-1:0] C_LAST  = CW'(NUM_BOIDS - 1);

   seq_state_e           r_state;
   seq_state_e           w_next;
   logic [CW-1:0]        r_self;
   logic [CW-1:0]        r_nbr;
   logic [CW-1:0]        w_self_next;
   logic [CW-1:0]        w_nbr_next;
   logic [CW-1:0]        w_nbr_step;
   logic [NUM_LANES-1:0] w_lane_ok;
   logic                 w_level;
   logic                 w_trig;
   logic                 w_wb_release;

   assign w_level      = en | is_refilling;
   assign w_nbr_step   = r_nbr + C_LANES;
   assign w_wb_release = !(step_mode && !step);

   boid_fall_edge_det u_trig (
      .clk     (clk),
      .reset_n (reset_n),
      .i_level (w_level),
      .o_fall  (w_trig)
   );

   // State and both counters move together on every clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_self  <= '0;
         r_nbr   <= '0;
      end else begin
         r_state <= w_next;
         r_self  <= w_self_next;
         r_nbr   <= w_nbr_next;
      end
   end

   // Next-state and counter update. Triggers outside IDLE are simply dropped,
   // and all-masked groups are still visited so frame timing never depends
   // on the data.
   always_comb begin
      w_next      = r_state;
      w_self_next = r_self;
      w_nbr_next  = r_nbr;
      case (r_state)
         IDLE: begin
            w_self_next = '0;
            w_nbr_next  = '0;
            if (w_trig) w_next = SA_INIT;
         end
         SA_INIT: begin
            if (mem_valid) w_next = SA_LD;
         end
         SA_LD: begin
            if (mem_valid) w_next = SA_CALC;
         end
         SA_CALC: begin
            w_nbr_next = w_nbr_step;
            w_next     = (w_nbr_step >= C_BOIDS) ? AC_WB : SA_LD;
         end
         AC_WB: begin
            if (w_wb_release) begin
               w_nbr_next = '0;
               if (r_self == C_LAST) begin
                  w_self_next = '0;
                  w_next      = IDLE;
               end else begin
                  w_self_next = r_self + CW'(1);
                  w_next      = SA_INIT;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // A lane is valid when its neighbour exists and is not self.
   always_comb begin
      w_lane_ok = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         w_lane_ok[l] = ((r_nbr + CW'(l)) < C_BOIDS) && ((r_nbr + CW'(l)) != r_self);
      end
   end

   // Output decode from registered state and counters. frame_done marks the
   // AC_WB exit cycle, so it also reflects the step release of that cycle.
   always_comb begin
      which_boid = '0;
      nbr_base   = '0;
      lane_mask  = '0;
      r_en_tot   = 1'b0;
      r_en_itr   = 1'b0;
      calc_en    = 1'b0;
      wb_en      = '0;
      busy       = (r_state != IDLE);
      frame_done = 1'b0;
      case (r_state)
         SA_INIT: begin
            r_en_tot   = 1'b1;
            which_boid = r_self[IW-1:0];
         end
         SA_LD: begin
            r_en_itr   = 1'b1;
            which_boid = r_self[IW-1:0];
            nbr_base   = r_nbr[IW-1:0];
            lane_mask  = w_lane_ok;
         end
         SA_CALC: begin
            calc_en    = 1'b1;
            lane_mask  = w_lane_ok;
         end
         AC_WB: begin
            wb_en      = WB_MASK;
            which_boid = r_self[IW-1:0];
            frame_done = w_wb_release && (r_self == C_LAST);
         end
         default: ;
      endcase
   end

endmodule
